call_issuer: RTL

- Upstream driver for the two-operand `start/done` callee block (`start`, `a`, `b` in; `result`, `done` out; `result = a + b`).
- Buffers operand pairs arriving on a valid/ready stream and issues one callee invocation per pair.
- Tracks the callee's `done` handshake and returns each result on a valid/ready output stream, in order.
- Sits between the operand producer and the callee; the callee's outputs feed back into this block.

---
 rtl/call_issuer_pkg.sv | 15 +
 rtl/operand_fifo.sv | 67 ++++++
 rtl/call_issuer.sv | 125 ++++++++++++
 3 files changed

// File: rtl/call_issuer_pkg.sv
// Shared types and defaults for the call issuer and its operand FIFO.
package call_issuer_pkg;

    localparam int unsigned DefaultWidth = 32;
    localparam int unsigned DefaultDepth = 4;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_LOW,
        WAIT_HIGH,
        OUTPUT
    } call_state_t;

endpackage

// File: rtl/operand_fifo.sv
// Synchronous FIFO holding operand pairs; no bypass, head visible the cycle after a push.
module operand_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               push_i,
    input  logic [2*WIDTH-1:0] data_i,
    input  logic               pop_i,
    output logic [2*WIDTH-1:0] data_o,
    output logic               full_o,
    output logic               empty_o
);

    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [PtrW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PtrW:0]      count_q, count_d;
    logic [2*WIDTH-1:0] mem_q [DEPTH];
    logic               do_push, do_pop;

    assign full_o  = (count_q == (PtrW + 1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign data_o  = mem_q[rd_ptr_q];

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // DEPTH is a power of two, so pointer overflow is the modulo wrap.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (do_push) begin
                mem_q[wr_ptr_q] <= data_i;
            end
        end
    end

endmodule

// File: rtl/call_issuer.sv
// Buffers operand pairs, drives one start/done callee invocation per pair and
// returns results in order on a valid/ready stream.
module call_issuer
    import call_issuer_pkg::*;
#(
    parameter int unsigned WIDTH = DefaultWidth,
    parameter int unsigned DEPTH = DefaultDepth
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             call_start,
    output logic [WIDTH-1:0] call_a,
    output logic [WIDTH-1:0] call_b,
    input  logic [WIDTH-1:0] call_result,
    input  logic             call_done,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result
);

    call_state_t        state_q, state_d;
    logic               call_start_q, call_start_d;
    logic [WIDTH-1:0]   call_a_q, call_a_d;
    logic [WIDTH-1:0]   call_b_q, call_b_d;
    logic               out_valid_q, out_valid_d;
    logic [WIDTH-1:0]   out_result_q, out_result_d;
    logic               ready_en_q;

    logic               fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [2*WIDTH-1:0] fifo_head;

    // Keeps in_ready low until the first edge after reset release.
    assign in_ready  = ready_en_q && !fifo_full;
    assign fifo_push = in_valid && in_ready;
    assign fifo_pop  = (state_q == ISSUE);

    operand_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_operand_fifo (
        .clk_i   (clk),
        .rst_ni  (reset),
        .push_i  (fifo_push),
        .data_i  ({in_a, in_b}),
        .pop_i   (fifo_pop),
        .data_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_comb begin
        state_d      = state_q;
        call_start_d = 1'b0;
        call_a_d     = call_a_q;
        call_b_d     = call_b_q;
        out_valid_d  = out_valid_q;
        out_result_d = out_result_q;
        unique case (state_q)
            IDLE: begin
                // call_done high means the callee is idle and can take a start.
                if (!fifo_empty && call_done) begin
                    call_a_d     = fifo_head[2*WIDTH-1:WIDTH];
                    call_b_d     = fifo_head[WIDTH-1:0];
                    call_start_d = 1'b1;
                    state_d      = ISSUE;
                end
            end
            ISSUE: begin
                state_d = WAIT_LOW;
            end
            WAIT_LOW: begin
                if (!call_done) begin
                    state_d = WAIT_HIGH;
                end
            end
            WAIT_HIGH: begin
                if (call_done) begin
                    out_result_d = call_result;
                    out_valid_d  = 1'b1;
                    state_d      = OUTPUT;
                end
            end
            OUTPUT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            call_start_q <= 1'b0;
            call_a_q     <= '0;
            call_b_q     <= '0;
            out_valid_q  <= 1'b0;
            out_result_q <= '0;
            ready_en_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            call_start_q <= call_start_d;
            call_a_q     <= call_a_d;
            call_b_q     <= call_b_d;
            out_valid_q  <= out_valid_d;
            out_result_q <= out_result_d;
            ready_en_q   <= 1'b1;
        end
    end

    assign call_start = call_start_q;
    assign call_a     = call_a_q;
    assign call_b     = call_b_q;
    assign out_valid  = out_valid_q;
    assign out_result = out_result_q;

endmodule
